// File: rtl/b01_word_collector.sv
// Collects LSB-first serial bits from the b01 FSM into WIDTH-bit words with a
// sticky overflow flag, and queues completed words in a 2-entry valid/ready FIFO.
module b01_word_collector #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             frame_start,
  input  logic             outp,
  input  logic             overflw,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             drop_err,
  output logic             abort_err,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int unsigned BCNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [WIDTH-1:0]    sreg_q, sreg_d;
  logic                ovf_q, ovf_d;
  logic [1:0]          fcnt_q, fcnt_d;
  logic [WIDTH-1:0]    head_data_q, head_data_d;
  logic                head_ovf_q, head_ovf_d;
  logic [WIDTH-1:0]    tail_data_q, tail_data_d;
  logic                tail_ovf_q, tail_ovf_d;
  logic                valid_q, valid_d;
  logic                drop_q, drop_d;
  logic                abort_q, abort_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;

  logic [WIDTH:0]      shift_in;
  logic [WIDTH:0]      first_in;
  logic                push;
  logic [WIDTH-1:0]    push_data;
  logic                push_ovf;
  logic                pop;

  // Bit collector: new bits enter at the MSB so the first bit lands in bit 0.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    sreg_d    = sreg_q;
    ovf_d     = ovf_q;
    abort_d   = 1'b0;
    push      = 1'b0;
    push_data = '0;
    push_ovf  = 1'b0;
    shift_in  = {outp, sreg_q};
    first_in  = {outp, WIDTH'(0)};
    if (in_valid) begin
      if (frame_start) begin
        abort_d = (state_q == COLLECT);
        sreg_d  = first_in[WIDTH:1];
        ovf_d   = overflw;
        bcnt_d  = BCNT_W'(1);
        state_d = COLLECT;
      end else if (state_q == COLLECT) begin
        sreg_d  = shift_in[WIDTH:1];
        ovf_d   = ovf_q | overflw;
        bcnt_d  = bcnt_q + BCNT_W'(1);
      end
      if (bcnt_d == BCNT_W'(WIDTH)) begin
        push      = 1'b1;
        push_data = sreg_d;
        push_ovf  = ovf_d;
        state_d   = IDLE;
        bcnt_d    = '0;
      end
    end
  end

  // Two-entry FIFO with the head held in its own output register.
  always_comb begin
    pop         = valid_q & out_ready;
    fcnt_d      = fcnt_q;
    head_data_d = head_data_q;
    head_ovf_d  = head_ovf_q;
    tail_data_d = tail_data_q;
    tail_ovf_d  = tail_ovf_q;
    drop_d      = 1'b0;
    wcnt_d      = pop ? wcnt_q + CNT_W'(1) : wcnt_q;
    case (fcnt_q)
      2'd0: begin
        if (push) begin
          head_data_d = push_data;
          head_ovf_d  = push_ovf;
          fcnt_d      = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = push_data;
          head_ovf_d  = push_ovf;
        end else if (push) begin
          tail_data_d = push_data;
          tail_ovf_d  = push_ovf;
          fcnt_d      = 2'd2;
        end else if (pop) begin
          fcnt_d      = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_ovf_d  = tail_ovf_q;
          if (push) begin
            tail_data_d = push_data;
            tail_ovf_d  = push_ovf;
          end else begin
            fcnt_d      = 2'd1;
          end
        end else if (push) begin
          drop_d = 1'b1;
        end
      end
    endcase
    valid_d = (fcnt_d != 2'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      sreg_q      <= '0;
      ovf_q       <= 1'b0;
      fcnt_q      <= 2'd0;
      head_data_q <= '0;
      head_ovf_q  <= 1'b0;
      tail_data_q <= '0;
      tail_ovf_q  <= 1'b0;
      valid_q     <= 1'b0;
      drop_q      <= 1'b0;
      abort_q     <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      sreg_q      <= sreg_d;
      ovf_q       <= ovf_d;
      fcnt_q      <= fcnt_d;
      head_data_q <= head_data_d;
      head_ovf_q  <= head_ovf_d;
      tail_data_q <= tail_data_d;
      tail_ovf_q  <= tail_ovf_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
      abort_q     <= abort_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = head_data_q;
  assign out_ovf   = head_ovf_q;
  assign drop_err  = drop_q;
  assign abort_err = abort_q;
  assign word_cnt  = wcnt_q;

endmodule

// File: tb/tb_b01_word_collector.sv
// Directed bench for b01_word_collector; popped words are checked against a
// queue of expected words filled as frames are driven.
module tb_b01_word_collector;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [W-1:0] d;
    logic         o;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic          outp = 1'b0;
  logic          overflw = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic          drop_err;
  logic          abort_err;
  logic [CW-1:0] word_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  int   drop_seen = 0;
  int   abort_seen = 0;

  b01_word_collector #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .outp        (outp),
    .overflw     (overflw),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .drop_err    (drop_err),
    .abort_err   (abort_err),
    .word_cnt    (word_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; any handshake seen at that edge is scored against the queue.
  task automatic tick();
    logic         pv, pr, po;
    logic [W-1:0] pd;
    exp_t         e;
    pv = out_valid; pr = out_ready; pd = out_data; po = out_ovf;
    @(posedge clock); #1;
    if (pv && pr) begin
      exp_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL pop_unexpected observed=0x%0h expected=none", pd);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_data", 32'(pd), 32'(e.d));
        chk("pop_ovf", 32'(po), 32'(e.o));
      end
      chk("word_cnt_pop", 32'(word_cnt), 32'(exp_cnt));
    end
    drop_seen  += int'(drop_err);
    abort_seen += int'(abort_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      tick();
    end
  endtask

  task automatic send_bit(input logic fs, input logic b, input logic ov);
    @(negedge clock);
    in_valid = 1'b1; frame_start = fs; outp = b; overflw = ov;
    tick();
    in_valid = 1'b0; frame_start = 1'b0; outp = 1'b0; overflw = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic [W-1:0] m,
                            input bit exp_push, input bit ready_last);
    if (exp_push) sb.push_back('{d: d, o: |m});
    for (int i = 0; i < W; i++) begin
      if (ready_last && i == W - 1) out_ready = 1'b1;
      send_bit(i == 0, d[i], m[i]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_data"}, 32'(out_data), 32'(0));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(0));
    chk({tag, "_drop"}, 32'(drop_err), 32'(0));
    chk({tag, "_abort"}, 32'(abort_err), 32'(0));
    chk({tag, "_cnt"}, 32'(word_cnt), 32'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; frame_start = 1'b0; outp = 1'b0; overflw = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_idle_outputs("rst_high");
    reset = 1'b0;
    sb.delete();
    exp_cnt = 0; drop_seen = 0; abort_seen = 0;
    @(posedge clock); #1;
    check_idle_outputs("rst_rel");
  endtask

  initial begin
    // Basic frame 0x4D, latency and pop
    do_reset();
    out_ready = 1'b1;
    send_frame(8'h4D, 8'h00, 1'b1, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'(1));
    chk("t1_data", 32'(out_data), 32'h4D);
    chk("t1_ovf", 32'(out_ovf), 32'(0));
    idle(1);
    chk("t1_cnt", 32'(word_cnt), 32'(1));
    chk("t1_empty", 32'(out_valid), 32'(0));

    // Sticky overflow on bit 3, cleared for the next word
    send_frame(8'h4D, 8'h08, 1'b1, 1'b0);
    chk("t2_ovf_set", 32'(out_ovf), 32'(1));
    send_frame(8'h5A, 8'h00, 1'b1, 1'b0);
    chk("t2_ovf_clr", 32'(out_ovf), 32'(0));
    chk("t2_data", 32'(out_data), 32'h5A);
    idle(1);
    chk("t2_cnt", 32'(word_cnt), 32'(3));

    // Overfill: third word dropped
    do_reset();
    send_frame(8'h01, 8'h00, 1'b1, 1'b0);
    send_frame(8'h02, 8'h00, 1'b1, 1'b0);
    chk("t3_no_drop_yet", 32'(drop_seen), 32'(0));
    send_frame(8'h03, 8'h00, 1'b0, 1'b0);
    chk("t3_drop_pulse", 32'(drop_err), 32'(1));
    idle(1);
    chk("t3_drop_once", 32'(drop_seen), 32'(1));
    chk("t3_head_stable", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    idle(3);
    chk("t3_empty", 32'(out_valid), 32'(0));
    chk("t3_cnt", 32'(word_cnt), 32'(2));
    chk("t3_sb_drained", 32'(sb.size()), 32'(0));

    // Abort: new frame_start on bit 5 of a partial word
    abort_seen = 0;
    send_bit(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b0);
    chk("t4_no_abort_yet", 32'(abort_seen), 32'(0));
    sb.push_back('{d: 8'hA5, o: 1'b0});
    begin
      logic [W-1:0] a5;
      a5 = 8'hA5;
      for (int i = 0; i < W; i++) begin
        send_bit(i == 0, a5[i], 1'b0);
        if (i == 0) chk("t4_abort_pulse", 32'(abort_err), 32'(1));
      end
    end
    chk("t4_abort_once", 32'(abort_seen), 32'(1));
    chk("t4_data", 32'(out_data), 32'hA5);
    idle(2);
    chk("t4_one_word", 32'(out_valid), 32'(0));
    chk("t4_cnt", 32'(word_cnt), 32'(3));

    // Full FIFO with simultaneous push and pop
    do_reset();
    send_frame(8'h11, 8'h00, 1'b1, 1'b0);
    send_frame(8'h22, 8'h01, 1'b1, 1'b0);
    send_frame(8'h33, 8'h00, 1'b1, 1'b1);
    out_ready = 1'b0;
    chk("t5_no_drop", 32'(drop_seen), 32'(0));
    chk("t5_head", 32'(out_data), 32'h22);
    chk("t5_head_ovf", 32'(out_ovf), 32'(1));
    send_frame(8'h44, 8'h00, 1'b0, 1'b0);
    chk("t5_still_full", 32'(drop_err), 32'(1));
    out_ready = 1'b1;
    idle(3);
    chk("t5_empty", 32'(out_valid), 32'(0));
    chk("t5_sb_drained", 32'(sb.size()), 32'(0));
    chk("t5_cnt", 32'(word_cnt), 32'(3));

    // Asynchronous reset mid-word with a word queued
    do_reset();
    out_ready = 1'b1;
    send_frame(8'h12, 8'h00, 1'b1, 1'b0);
    idle(1);
    out_ready = 1'b0;
    send_frame(8'h77, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 0, 1'b1, 1'b0);
    chk("t6_pre_valid", 32'(out_valid), 32'(1));
    chk("t6_pre_cnt", 32'(word_cnt), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("t6_async");
    sb.delete();
    exp_cnt = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    send_frame(8'h3C, 8'h00, 1'b1, 1'b0);
    chk("t6_valid", 32'(out_valid), 32'(1));
    chk("t6_data", 32'(out_data), 32'h3C);
    out_ready = 1'b1;
    idle(2);
    chk("t6_cnt", 32'(word_cnt), 32'(1));
    chk("t6_empty", 32'(out_valid), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b01_word_collector.md
Name: b01_word_collector

Overview:
- Downstream consumer of the b01 serial FSM.
- Samples the serial result bit (outp) and the overflow flag (overflw) on qualified cycles and assembles WIDTH bits, LSB first, into a parallel word with a sticky overflow flag.
- Completed words are queued in a 2-entry FIFO and presented on a valid/ready interface to the parallel-side logic.

Parameters:
- WIDTH, 8, number of serial bits per word.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  the current outp/overflw sample is a valid bit.
- frame_start  input  1  qualified by in_valid: the current bit is bit 0 of a new word.
- outp  input  1  serial result bit from b01.
- overflw  input  1  overflow indication from b01, sampled with each bit.
- out_ready  input  1  consumer accepts the head word.
- out_valid  output  1  FIFO non-empty.
- out_data  output  WIDTH  head word, bit i = i-th accepted bit.
- out_ovf  output  1  head word's sticky overflow flag.
- drop_err  output  1  one-cycle pulse: a completed word was lost because the FIFO was full.
- abort_err  output  1  one-cycle pulse: a partial word was discarded by a new frame_start.
- word_cnt  output  CNT_W  count of words popped; wraps from all-ones to 0.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, bit counter 0, shift register 0, sticky ovf 0, FIFO empty. All outputs 0 while reset is high and after release: out_valid, out_data, out_ovf, drop_err, abort_err, word_cnt.
- An accepted bit is a rising edge with in_valid=1. frame_start without in_valid is ignored.
- IDLE state:
  - in_valid=1 & frame_start=1: capture outp as bit 0, ovf_acc <= overflw, cnt <= 1, go to COLLECT.
  - in_valid=1 & frame_start=0: bit discarded silently, no error.
- COLLECT state:
  - in_valid=1 & frame_start=0: shift in outp (sreg <= {outp, sreg[WIDTH-1:1]}), ovf_acc <= ovf_acc | overflw, cnt++.
  - in_valid=1 & frame_start=1: abort_err=1 for the next cycle; partial word discarded; the current bit becomes bit 0 (cnt <= 1, ovf_acc <= overflw).
  - in_valid=0: hold all state, no timeout.
- Word completion:
  - The edge accepting bit WIDTH-1 writes {assembled word, ovf_acc | overflw} into the FIFO and returns the FSM to IDLE (cnt <= 0).
  - out_valid rises on the cycle after that edge when the FIFO was empty, so latency from last bit to out_valid is 1 cycle.
  - WIDTH=1: every frame_start bit completes a word immediately.
- FIFO (2 entries, registered head output):
  - Pop when out_valid & out_ready at the edge; word_cnt increments on the same edge.
  - Push when full and no pop on the same edge: word dropped, FIFO unchanged, drop_err=1 for one cycle.
  - Push and pop on the same edge when full: both succeed, no drop.
  - Push and pop on the same edge when holding 1 entry: count stays 1 and the head becomes the new word.
  - Order is strictly FIFO. out_data/out_ovf are stable while out_valid=1 & out_ready=0.
- Error pulses: registered, high exactly one cycle per event; independent of each other and of the handshake.
- Reset mid-operation: partial word, FIFO contents and counters lost immediately; no error pulse is generated.

Test Plan:
- Reset, then frame of outp bits 1,0,1,1,0,0,1,0 (frame_start on first bit), overflw=0, out_ready=1 -> out_valid=1 one cycle after bit 7 edge, out_data=0x4D, out_ovf=0, word_cnt=1 after the pop.
- Same frame with overflw=1 only on bit 3 -> out_data=0x4D, out_ovf=1. Next frame with overflw=0 throughout -> out_ovf=0 (sticky cleared per word).
- out_ready=0, three back-to-back frames 0x01, 0x02, 0x03 -> drop_err pulses once at the third completion. Then out_ready=1 -> pops 0x01 then 0x02, out_valid=0 after, word_cnt=2.
- frame_start reasserted with bit 5 of a partial word, followed by 7 more bits forming 0xA5 -> abort_err one-cycle pulse; out_data=0xA5, only one word delivered.
- FIFO full, out_ready=1 on the same edge the next word completes -> no drop_err, FIFO stays full, words delivered in order.
- Assert reset asynchronously (between edges) after 4 bits of a word with 1 word in the FIFO -> out_valid=0, word_cnt=0 immediately. After release, a full 0x3C frame delivers out_data=0x3C.
